// File: rtl/mips_dispatch_unit.sv
// In-order dispatch stage of the Tomasulo-style MIPS core.
// Decodes one instruction per cycle, reads source operands from the register
// file and register status table (RST), renames the destination with a 5-bit
// tag and steers the instruction to the integer, load/store or multiply issue
// queue. J is resolved here by redirecting ifetch.
module mips_dispatch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifetch_pc_4,
    input  logic [31:0] ifetch_intruction,
    input  logic        ifetch_empty,
    output logic [31:0] Dispatch_jmp_addr,
    output logic        Dispatch_jmp,
    output logic        Dispatch_ren,
    output logic [31:0] dispatch_rs_data,
    output logic        dispatch_rs_data_valid,
    output logic [4:0]  dispatch_rs_tag,
    output logic [31:0] dispatch_rt_data,
    output logic        dispatch_rt_data_valid,
    output logic [4:0]  dispatch_rt_tag,
    output logic [4:0]  dispatch_rd_tag,
    output logic        dispatch_en_integer,
    input  logic        issueque_integer_full,
    output logic [3:0]  dispatch_opcode,
    output logic [4:0]  dispatch_shfamt,
    output logic        dispatch_en_ld_st,
    input  logic        issueque_full_ld_st,
    output logic [15:0] dispatch_imm_ld_st,
    output logic        dispatch_en_mul,
    input  logic        issueque_mul_full
);

    // Which issue queue (if any) an instruction is steered to.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_INT,
        CLS_LDST,
        CLS_MUL,
        CLS_JMP
    } iclass_t;

    // Instruction fields
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs_addr;
    logic [4:0]  w_rt_addr;
    logic [4:0]  w_rd_addr;

    // Decode results
    iclass_t     w_class;
    logic [3:0]  w_opcode;
    logic        w_has_dest;
    logic [4:0]  w_dest;

    // Dispatch control
    logic        w_target_full;
    logic        w_dispatch;
    logic        w_rename;

    // Operand readiness
    logic        w_rs_ready;
    logic        w_rt_ready;

    // Architectural state
    logic [31:0] r_rf [32];
    logic [31:0] r_rst_pending;
    logic [4:0]  r_rst_tag [32];
    logic [4:0]  r_tag_cnt;

    // Only the region bits of PC+4 feed the jump target.
    logic        w_unused_pc;

    assign w_op        = ifetch_intruction[31:26];
    assign w_funct     = ifetch_intruction[5:0];
    assign w_rs_addr   = ifetch_intruction[25:21];
    assign w_rt_addr   = ifetch_intruction[20:16];
    assign w_rd_addr   = ifetch_intruction[15:11];
    assign w_unused_pc = ^ifetch_pc_4[27:0];

    // Decode opcode/funct into queue class, internal op code and destination.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case statements leaves it unassigned, which
        // would otherwise infer a latch.
        w_class    = CLS_NOP;
        w_opcode   = 4'd0;
        w_has_dest = 1'b0;
        w_dest     = 5'd0;
        case (w_op)
            6'h00: begin
                w_dest = w_rd_addr;
                case (w_funct)
                    6'h20: begin w_class = CLS_INT; w_opcode = 4'd0; end
                    6'h22: begin w_class = CLS_INT; w_opcode = 4'd1; end
                    6'h24: begin w_class = CLS_INT; w_opcode = 4'd2; end
                    6'h25: begin w_class = CLS_INT; w_opcode = 4'd3; end
                    6'h2A: begin w_class = CLS_INT; w_opcode = 4'd4; end
                    6'h00: begin w_class = CLS_INT; w_opcode = 4'd5; end
                    6'h02: begin w_class = CLS_INT; w_opcode = 4'd6; end
                    6'h19: begin w_class = CLS_MUL; w_opcode = 4'd7; end
                    default: ;
                endcase
                w_has_dest = (w_class != CLS_NOP);
            end
            6'h08: begin w_class = CLS_INT;  w_opcode = 4'd8;  w_has_dest = 1'b1; w_dest = w_rt_addr; end
            6'h0C: begin w_class = CLS_INT;  w_opcode = 4'd9;  w_has_dest = 1'b1; w_dest = w_rt_addr; end
            6'h0D: begin w_class = CLS_INT;  w_opcode = 4'd10; w_has_dest = 1'b1; w_dest = w_rt_addr; end
            6'h04: begin w_class = CLS_INT;  w_opcode = 4'd11; end
            6'h05: begin w_class = CLS_INT;  w_opcode = 4'd12; end
            6'h23: begin w_class = CLS_LDST; w_opcode = 4'd13; w_has_dest = 1'b1; w_dest = w_rt_addr; end
            6'h2B: begin w_class = CLS_LDST; w_opcode = 4'd14; end
            6'h02: begin w_class = CLS_JMP;  w_opcode = 4'd15; end
            default: ;
        endcase
    end

    // Select the full flag of the queue this instruction targets.
    always_comb begin
        w_target_full = 1'b0;
        case (w_class)
            CLS_INT:  w_target_full = issueque_integer_full;
            CLS_LDST: w_target_full = issueque_full_ld_st;
            CLS_MUL:  w_target_full = issueque_mul_full;
            default:  w_target_full = 1'b0;
        endcase
    end

    // An instruction leaves the ifetch queue only if its target has room.
    assign w_dispatch = !reset && !ifetch_empty && !w_target_full;
    // Writes to $0 never rename: $0 is always ready.
    assign w_rename   = w_dispatch && w_has_dest && (w_dest != 5'd0);

    assign Dispatch_ren        = w_dispatch;
    assign Dispatch_jmp        = w_dispatch && (w_class == CLS_JMP);
    assign Dispatch_jmp_addr   = {ifetch_pc_4[31:28], ifetch_intruction[25:0], 2'b00};
    assign dispatch_en_integer = w_dispatch && (w_class == CLS_INT);
    assign dispatch_en_ld_st   = w_dispatch && (w_class == CLS_LDST);
    assign dispatch_en_mul     = w_dispatch && (w_class == CLS_MUL);
    assign dispatch_opcode     = w_opcode;
    assign dispatch_shfamt     = ifetch_intruction[10:6];
    assign dispatch_imm_ld_st  = ifetch_intruction[15:0];
    assign dispatch_rd_tag     = r_tag_cnt;

    // Source operands see the RST as it was before this cycle's rename.
    always_comb begin
        w_rs_ready = (w_rs_addr == 5'd0) || !r_rst_pending[w_rs_addr];
        w_rt_ready = (w_rt_addr == 5'd0) || !r_rst_pending[w_rt_addr];

        dispatch_rs_data_valid = w_rs_ready;
        dispatch_rs_data       = w_rs_ready ? r_rf[w_rs_addr] : 32'd0;
        dispatch_rs_tag        = w_rs_ready ? 5'd0 : r_rst_tag[w_rs_addr];

        dispatch_rt_data_valid = w_rt_ready;
        dispatch_rt_data       = w_rt_ready ? r_rf[w_rt_addr] : 32'd0;
        dispatch_rt_tag        = w_rt_ready ? 5'd0 : r_rst_tag[w_rt_addr];
    end

    // Register file: loaded with RF[i]=i on reset; results arrive via the CDB later.
    always_ff @(posedge clock) begin
        // NOTE: the register file is reset explicitly because its reset contents
        // are architecturally visible operand values, not don't-cares.
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'(i);
            end
        end
    end

    // RST and tag counter: clear on reset, rename destination on dispatch.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // updates from values sampled before the edge, independent of statement order.
        if (reset) begin
            r_rst_pending <= 32'd0;
            r_tag_cnt     <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                r_rst_tag[i] <= 5'd0;
            end
        end else if (w_rename) begin
            r_rst_pending[w_dest] <= 1'b1;
            r_rst_tag[w_dest]     <= r_tag_cnt;
            r_tag_cnt             <= r_tag_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_mips_dispatch_unit.sv
// Scoreboard bench for mips_dispatch_unit: a stimulus process predicts each
// cycle's outputs from an abstract model and queues them; a monitor compares.
module tb_mips_dispatch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifetch_pc_4;
    logic [31:0] ifetch_intruction;
    logic        ifetch_empty;
    logic [31:0] Dispatch_jmp_addr;
    logic        Dispatch_jmp;
    logic        Dispatch_ren;
    logic [31:0] dispatch_rs_data;
    logic        dispatch_rs_data_valid;
    logic [4:0]  dispatch_rs_tag;
    logic [31:0] dispatch_rt_data;
    logic        dispatch_rt_data_valid;
    logic [4:0]  dispatch_rt_tag;
    logic [4:0]  dispatch_rd_tag;
    logic        dispatch_en_integer;
    logic        issueque_integer_full;
    logic [3:0]  dispatch_opcode;
    logic [4:0]  dispatch_shfamt;
    logic        dispatch_en_ld_st;
    logic        issueque_full_ld_st;
    logic [15:0] dispatch_imm_ld_st;
    logic        dispatch_en_mul;
    logic        issueque_mul_full;

    always #5 clock = ~clock;

    mips_dispatch_unit dut (
        .clock                  (clock),
        .reset                  (reset),
        .ifetch_pc_4            (ifetch_pc_4),
        .ifetch_intruction      (ifetch_intruction),
        .ifetch_empty           (ifetch_empty),
        .Dispatch_jmp_addr      (Dispatch_jmp_addr),
        .Dispatch_jmp           (Dispatch_jmp),
        .Dispatch_ren           (Dispatch_ren),
        .dispatch_rs_data       (dispatch_rs_data),
        .dispatch_rs_data_valid (dispatch_rs_data_valid),
        .dispatch_rs_tag        (dispatch_rs_tag),
        .dispatch_rt_data       (dispatch_rt_data),
        .dispatch_rt_data_valid (dispatch_rt_data_valid),
        .dispatch_rt_tag        (dispatch_rt_tag),
        .dispatch_rd_tag        (dispatch_rd_tag),
        .dispatch_en_integer    (dispatch_en_integer),
        .issueque_integer_full  (issueque_integer_full),
        .dispatch_opcode        (dispatch_opcode),
        .dispatch_shfamt        (dispatch_shfamt),
        .dispatch_en_ld_st      (dispatch_en_ld_st),
        .issueque_full_ld_st    (issueque_full_ld_st),
        .dispatch_imm_ld_st     (dispatch_imm_ld_st),
        .dispatch_en_mul        (dispatch_en_mul),
        .issueque_mul_full      (issueque_mul_full)
    );

    typedef struct {
        bit          in_reset;
        bit          ren, jmp, en_int, en_ldst, en_mul;
        bit          check_op;
        logic [3:0]  opcode;
        logic [31:0] jmp_addr;
        logic [4:0]  shfamt;
        logic [15:0] imm;
        logic [31:0] rs_data, rt_data;
        bit          rs_valid, rt_valid;
        logic [4:0]  rs_tag, rt_tag, rd_tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: mnemonic tables plus register status as plain arrays.
    int funct_map[int];
    int iop_map[int];
    bit m_pend[32];
    int m_tag[32];
    int m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] r_type(int funct, int rs, int rt, int rd, int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
    endfunction

    function automatic logic [31:0] i_type(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Predict one cycle, drive it, then advance the model across the clock edge.
    task automatic apply(input bit rst, input bit empty, input bit fi, input bit fl,
                         input bit fm, input logic [31:0] pc4, input logic [31:0] instr);
        exp_t e;
        int   op, funct, code, cls, dest, rs, rt;
        bit   full, disp;
        op    = int'(instr[31:26]);
        funct = int'(instr[5:0]);
        rs    = int'(instr[25:21]);
        rt    = int'(instr[20:16]);
        code  = -1;
        if (op == 0 && funct_map.exists(funct)) code = funct_map[funct];
        else if (op != 0 && iop_map.exists(op)) code = iop_map[op];
        // class: 0 none, 1 integer, 2 load/store, 3 multiply, 4 jump
        if (code < 0)                     cls = 0;
        else if (code == 7)               cls = 3;
        else if (code == 13 || code == 14) cls = 2;
        else if (code == 15)              cls = 4;
        else                              cls = 1;
        if (code >= 0 && code <= 7)                                dest = int'(instr[15:11]);
        else if (code == 8 || code == 9 || code == 10 || code == 13) dest = rt;
        else                                                       dest = -1;
        full = (cls == 1 && fi) || (cls == 2 && fl) || (cls == 3 && fm);
        disp = !rst && !empty && !full;

        e.in_reset = rst;
        e.ren      = disp;
        e.jmp      = disp && cls == 4;
        e.en_int   = disp && cls == 1;
        e.en_ldst  = disp && cls == 2;
        e.en_mul   = disp && cls == 3;
        e.check_op = (code >= 0);
        e.opcode   = 4'(code);
        e.jmp_addr = {pc4[31:28], instr[25:0], 2'b00};
        e.shfamt   = instr[10:6];
        e.imm      = instr[15:0];
        e.rs_valid = (rs == 0) || !m_pend[rs];
        e.rs_data  = e.rs_valid ? 32'(rs) : 32'd0;
        e.rs_tag   = e.rs_valid ? 5'd0 : 5'(m_tag[rs]);
        e.rt_valid = (rt == 0) || !m_pend[rt];
        e.rt_data  = e.rt_valid ? 32'(rt) : 32'd0;
        e.rt_tag   = e.rt_valid ? 5'd0 : 5'(m_tag[rt]);
        e.rd_tag   = 5'(m_cnt);
        sb_q.push_back(e);

        reset                 = rst;
        ifetch_empty          = empty;
        issueque_integer_full = fi;
        issueque_full_ld_st   = fl;
        issueque_mul_full     = fm;
        ifetch_pc_4           = pc4;
        ifetch_intruction     = instr;

        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 1'b0;
                m_tag[i]  = 0;
            end
            m_cnt = 0;
        end else if (disp && dest > 0) begin
            m_pend[dest] = 1'b1;
            m_tag[dest]  = m_cnt;
            m_cnt        = (m_cnt + 1) % 32;
        end
        #1;
    endtask

    function automatic int rand_reg();
        if ($urandom_range(0, 4) == 0) return ($urandom_range(0, 1) == 0) ? 0 : 31;
        return int'($urandom_range(1, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        int r_functs[7] = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h00, 'h02};
        int i_ops[7]    = '{'h08, 'h0C, 'h0D, 'h04, 'h05, 'h23, 'h2B};
        k = int'($urandom_range(0, 17));
        if (k <= 6)  return r_type(r_functs[k], rand_reg(), rand_reg(), rand_reg(), int'($urandom_range(0, 31)));
        if (k == 7)  return r_type('h19, rand_reg(), rand_reg(), rand_reg(), 0);
        if (k <= 14) return i_type(i_ops[k - 8], rand_reg(), rand_reg(), int'($urandom_range(0, 65535)));
        if (k == 15) return {6'h02, 26'($urandom)};
        if (k == 16) return r_type('h3F, rand_reg(), rand_reg(), rand_reg(), 0);
        return 32'($urandom);
    endfunction

    // Monitor: compare the DUT against the queued prediction mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ren",       32'(Dispatch_ren),        32'(e.ren));
                check("jmp",       32'(Dispatch_jmp),        32'(e.jmp));
                check("en_int",    32'(dispatch_en_integer), 32'(e.en_int));
                check("en_ldst",   32'(dispatch_en_ld_st),   32'(e.en_ldst));
                check("en_mul",    32'(dispatch_en_mul),     32'(e.en_mul));
                if (!e.in_reset) begin
                    if (e.check_op) check("opcode", 32'(dispatch_opcode), 32'(e.opcode));
                    check("jmp_addr", Dispatch_jmp_addr,           e.jmp_addr);
                    check("shfamt",   32'(dispatch_shfamt),        32'(e.shfamt));
                    check("imm",      32'(dispatch_imm_ld_st),     32'(e.imm));
                    check("rs_data",  dispatch_rs_data,            e.rs_data);
                    check("rs_valid", 32'(dispatch_rs_data_valid), 32'(e.rs_valid));
                    check("rs_tag",   32'(dispatch_rs_tag),        32'(e.rs_tag));
                    check("rt_data",  dispatch_rt_data,            e.rt_data);
                    check("rt_valid", 32'(dispatch_rt_data_valid), 32'(e.rt_valid));
                    check("rt_tag",   32'(dispatch_rt_tag),        32'(e.rt_tag));
                    check("rd_tag",   32'(dispatch_rd_tag),        32'(e.rd_tag));
                end
            end
        end
    end

    // Watchdog: a stalled run still reports and ends.
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, %0d predictions pending", sb_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Stimulus: directed scenarios, tag wrap, then randomized traffic.
    initial begin
        logic [31:0] add_31, mul_2, add_1, jmp_i;
        funct_map['h20] = 0;  funct_map['h22] = 1;  funct_map['h24] = 2;
        funct_map['h25] = 3;  funct_map['h2A] = 4;  funct_map['h00] = 5;
        funct_map['h02] = 6;  funct_map['h19] = 7;
        iop_map['h08] = 8;    iop_map['h0C] = 9;    iop_map['h0D] = 10;
        iop_map['h04] = 11;   iop_map['h05] = 12;   iop_map['h23] = 13;
        iop_map['h2B] = 14;   iop_map['h02] = 15;
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 1'b0;
            m_tag[i]  = 0;
        end
        m_cnt = 0;

        add_31 = 32'h0080F820;   // add $31,$4,$0
        mul_2  = 32'h00BF1019;   // mul $2,$5,$31
        add_1  = r_type('h20, 2, 3, 1, 0);
        jmp_i  = 32'h08000010;

        reset = 1'b1; ifetch_empty = 1'b1; ifetch_pc_4 = 32'd0; ifetch_intruction = 32'd0;
        issueque_integer_full = 1'b0; issueque_full_ld_st = 1'b0; issueque_mul_full = 1'b0;
        @(posedge clock);
        #1;

        apply(1, 0, 0, 0, 0, 32'h4, add_31);
        apply(0, 0, 0, 0, 0, 32'h4, add_31);
        apply(0, 0, 0, 0, 0, 32'h4, add_31);
        apply(0, 0, 0, 0, 0, 32'h8, mul_2);
        apply(1, 0, 0, 0, 0, 32'h4, add_31);
        apply(0, 0, 0, 0, 0, 32'h4, add_31);
        apply(0, 0, 0, 0, 0, 32'h8, mul_2);
        apply(0, 0, 1, 0, 0, 32'hC, add_31);
        apply(0, 0, 1, 0, 0, 32'hC, add_31);
        apply(0, 0, 0, 0, 0, 32'hC, add_31);
        apply(0, 0, 0, 0, 1, 32'h10, mul_2);
        apply(0, 0, 0, 1, 0, 32'h14, i_type('h23, 31, 6, 'h1234));
        apply(0, 0, 0, 0, 0, 32'h14, i_type('h23, 31, 6, 'h1234));
        apply(0, 0, 1, 1, 1, 32'h40000004, jmp_i);
        apply(0, 1, 0, 0, 0, 32'h40000004, add_31);
        apply(0, 0, 1, 1, 1, 32'h18, r_type('h3F, 6, 31, 7, 0));
        apply(0, 0, 0, 0, 0, 32'h1C, r_type('h00, 0, 2, 9, 13));
        apply(1, 0, 0, 0, 0, 32'h20, add_31);
        for (int i = 0; i < 33; i++) apply(0, 0, 0, 0, 0, 32'h24, add_1);
        apply(0, 0, 0, 0, 0, 32'h28, r_type('h20, 1, 0, 0, 0));

        for (int i = 0; i < 2500; i++) begin
            apply($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20,
                  32'($urandom), rand_instr());
        end

        @(posedge clock);
        @(posedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
